// File: rtl/pin_pkg.sv
// Shared types and constants for the 2-bit PIN entry initiator.
package pin_pkg;

  localparam int DIGIT_W = 2;
  localparam logic [DIGIT_W-1:0] IDLE_PATTERN = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    WAIT_ACK = 3'd2,
    DONE     = 3'd3,
    FAIL     = 3'd4
  } state_t;

endpackage

// File: rtl/pin_timer.sv
// Up-counter that loads zero on clr, counts on en and saturates at LIMIT-1,
// flagging the terminal count on tc.
module pin_timer #(
  parameter int WIDTH = 3,
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/pin_sender.sv
// PIN entry initiator: sends a latched digit sequence on d0/d1, waits for the
// lock's unlock indication, resends on timeout and reports done or fail.
//
// state    | meaning
// IDLE     | lines at idle pattern, waiting for start
// SEND     | driving latched digit idx for HOLD_CYCLES cycles each
// WAIT_ACK | lines idle, waiting up to TIMEOUT_CYCLES for unlock
// DONE     | one-cycle done pulse
// FAIL     | one-cycle fail pulse, retries exhausted
module pin_sender
  import pin_pkg::*;
#(
  parameter int NUM_DIGITS     = 3,
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 8,
  parameter int MAX_RETRIES    = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [2*NUM_DIGITS-1:0]           code,
  input  logic                              unlock,
  output logic                              d0,
  output logic                              d1,
  output logic                              busy,
  output logic                              done,
  output logic                              fail,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_idx,
  output logic [2:0]                        state_dbg
);

  localparam int IW = $clog2(NUM_DIGITS + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // Two extra codes keep the retry counter at least one bit wide when MAX_RETRIES is 0.
  localparam int RW = $clog2(MAX_RETRIES + 2);
  localparam int CW = DIGIT_W * NUM_DIGITS;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  state_t          state, state_nxt;
  logic [CW-1:0]   shadow;
  logic            shadow_ld;
  logic [IW-1:0]   idx, idx_nxt;
  logic [RW-1:0]   retry, retry_nxt;
  logic            hold_clr, hold_en, hold_tc;
  logic            tmo_clr, tmo_en, tmo_tc;
  logic [DIGIT_W-1:0] cur_digit;
  logic [DIGIT_W-1:0] lines;

  pin_timer #(
    .WIDTH (HW),
    .LIMIT (HOLD_CYCLES)
  ) u_hold (
    .clk (clk),
    .rst (rst),
    .clr (hold_clr),
    .en  (hold_en),
    .tc  (hold_tc)
  );

  pin_timer #(
    .WIDTH (TW),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk (clk),
    .rst (rst),
    .clr (tmo_clr),
    .en  (tmo_en),
    .tc  (tmo_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      shadow <= '0;
      idx    <= '0;
      retry  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      retry <= retry_nxt;
      if (shadow_ld) begin
        shadow <= code;
      end
    end
  end

  // Each timer is held at zero outside the state that uses it, so entering
  // SEND or WAIT_ACK always starts from a fresh count.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    retry_nxt = retry;
    shadow_ld = 1'b0;
    hold_clr  = (state != SEND);
    hold_en   = 1'b0;
    tmo_clr   = (state != WAIT_ACK);
    tmo_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          shadow_ld = 1'b1;
          idx_nxt   = '0;
          retry_nxt = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (unlock && (idx == LAST_IDX)) begin
          state_nxt = DONE;
        end else if (hold_tc) begin
          hold_clr = 1'b1;
          if (idx != LAST_IDX) begin
            idx_nxt = idx + IW'(1);
          end else begin
            state_nxt = WAIT_ACK;
          end
        end else begin
          hold_en = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (unlock) begin
          state_nxt = DONE;
        end else if (tmo_tc) begin
          if (retry != RETRY_MAX) begin
            retry_nxt = retry + RW'(1);
            idx_nxt   = '0;
            state_nxt = SEND;
          end else begin
            state_nxt = FAIL;
          end
        end else begin
          tmo_en = 1'b1;
        end
      end
      DONE, FAIL: begin
        idx_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign cur_digit = shadow[idx*DIGIT_W +: DIGIT_W];
  assign lines     = (state == SEND) ? cur_digit : IDLE_PATTERN;

  assign d0        = lines[0];
  assign d1        = lines[1];
  assign busy      = (state == SEND) || (state == WAIT_ACK);
  assign done      = (state == DONE);
  assign fail      = (state == FAIL);
  assign digit_idx = idx;
  assign state_dbg = state;

endmodule
